// File: rtl/program_sequencer.sv
// ---------------------------------------------------------------------------
// program_sequencer
//
// Program-load and instruction-issue stage that sits directly in front of the
// processor controller. The host streams 20-bit instructions as three bytes
// (A, B, then opcode in the low nibble) into a small program memory. After a
// start pulse, the sequencer fetches the word at the controller's current
// address and presents it with a one-cycle op pulse. Pulses are paced to
// match the controller's instruction cadence.
//
// Word layout in memory: [19:16] opcode, [15:8] operand B, [7:0] operand A.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high reset
//   wr_valid  in   host byte valid
//   wr_data   in   [7:0] host byte
//   wr_ready  out  sequencer can accept a byte (LOAD and memory not full)
//   start     in   begin executing the loaded program (1-cycle pulse)
//   addr_in   in   [3:0] controller's current instruction address
//   opcode    out  [3:0] opcode to controller
//   instr_a   out  [7:0] operand A
//   instr_b   out  [7:0] operand B
//   op        out  instruction-valid pulse (high only in ISSUE)
//   prog_len  out  [4:0] number of complete words loaded, 0..16
//   running   out  high in FETCH/ISSUE/WAIT
//   done      out  high once every loaded word has been issued
//
// ISSUE_GAP is the number of idle cycles after each op pulse before the next
// fetch. Values below 2 would outrun the controller and are not supported.
// ---------------------------------------------------------------------------
module program_sequencer #(
  parameter int DEPTH     = 16,
  parameter int ISSUE_GAP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic       start,
  input  logic [3:0] addr_in,
  output logic [3:0] opcode,
  output logic [7:0] instr_a,
  output logic [7:0] instr_b,
  output logic       op,
  output logic [4:0] prog_len,
  output logic       running,
  output logic       done
);

  localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  typedef enum logic [2:0] {
    S_LOAD,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
  logic [4:0]         issue_cnt_reg, issue_cnt_next;

  logic [1:0]         phase_reg;
  logic [7:0]         a_byte_reg;
  logic [7:0]         b_byte_reg;
  logic [3:0]         wr_ptr_reg;
  logic [4:0]         prog_len_reg;

  logic [3:0]         opcode_reg;
  logic [7:0]         instr_a_reg;
  logic [7:0]         instr_b_reg;

  // Program memory. No reset: prog_len=0 is what marks the contents invalid.
  logic [19:0]        mem [DEPTH];

  logic               byte_accept;
  logic               word_write;
  logic               start_ok;

  assign wr_ready    = (state_reg == S_LOAD) && (prog_len_reg < 5'(DEPTH));
  assign byte_accept = wr_valid && wr_ready;
  assign word_write  = byte_accept && (phase_reg == 2'd2);

  // A byte accepted in the same cycle takes priority, so start is dropped
  // then; start is also refused mid-word or with an empty program.
  assign start_ok = (state_reg == S_LOAD) && start && (prog_len_reg != 5'd0) &&
                    (phase_reg == 2'd0) && !byte_accept;

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_LOAD;
      gap_cnt_reg   <= '0;
      issue_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      gap_cnt_reg   <= gap_cnt_next;
      issue_cnt_reg <= issue_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    gap_cnt_next   = gap_cnt_reg;
    issue_cnt_next = issue_cnt_reg;
    case (state_reg)
      S_LOAD: begin
        if (start_ok) begin
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        state_next = S_ISSUE;
      end
      S_ISSUE: begin
        issue_cnt_next = issue_cnt_reg + 5'd1;
        gap_cnt_next   = '0;
        if ((issue_cnt_reg + 5'd1) == prog_len_reg) begin
          state_next = S_DONE;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (gap_cnt_reg == GAP_W'(ISSUE_GAP - 1)) begin
          state_next = S_FETCH;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_DONE;
      end
      default: begin
        state_next = S_LOAD;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Host byte assembly and load bookkeeping
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_reg    <= 2'd0;
      a_byte_reg   <= 8'd0;
      b_byte_reg   <= 8'd0;
      wr_ptr_reg   <= 4'd0;
      prog_len_reg <= 5'd0;
    end else if (byte_accept) begin
      case (phase_reg)
        2'd0: begin
          a_byte_reg <= wr_data;
          phase_reg  <= 2'd1;
        end
        2'd1: begin
          b_byte_reg <= wr_data;
          phase_reg  <= 2'd2;
        end
        default: begin
          phase_reg    <= 2'd0;
          wr_ptr_reg   <= wr_ptr_reg + 4'd1;
          prog_len_reg <= prog_len_reg + 5'd1;
        end
      endcase
    end
  end

  // Memory write port; the upper nibble of the opcode byte is discarded.
  always_ff @(posedge clk) begin
    if (word_write && !reset) begin
      mem[wr_ptr_reg] <= {wr_data[3:0], b_byte_reg, a_byte_reg};
    end
  end

  // Registered read in FETCH. The outputs hold their last fetched values in
  // every other state.
  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_reg  <= 4'd0;
      instr_a_reg <= 8'd0;
      instr_b_reg <= 8'd0;
    end else if (state_reg == S_FETCH) begin
      opcode_reg  <= mem[addr_in][19:16];
      instr_b_reg <= mem[addr_in][15:8];
      instr_a_reg <= mem[addr_in][7:0];
    end
  end

  assign opcode   = opcode_reg;
  assign instr_a  = instr_a_reg;
  assign instr_b  = instr_b_reg;
  assign op       = (state_reg == S_ISSUE);
  assign prog_len = prog_len_reg;
  assign running  = (state_reg == S_FETCH) || (state_reg == S_ISSUE) ||
                    (state_reg == S_WAIT);
  assign done     = (state_reg == S_DONE);

endmodule

// File: tb/tb_program_sequencer.sv
// ---------------------------------------------------------------------------
// tb_program_sequencer
//
// Directed testbench for program_sequencer. It loads programs byte by byte,
// models the controller (addr_in advances after every op pulse), and checks
// op timing and contents, done timing, load guards, full-memory behaviour
// and mid-run reset against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_program_sequencer;

  logic       clk;
  logic       reset;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       start;
  logic [3:0] addr_in;
  logic [3:0] opcode;
  logic [7:0] instr_a;
  logic [7:0] instr_b;
  logic       op;
  logic [4:0] prog_len;
  logic       running;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_a  [16];
  logic [7:0] exp_b  [16];
  logic [3:0] exp_op [16];

  program_sequencer #(.DEPTH(16), .ISSUE_GAP(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .start    (start),
    .addr_in  (addr_in),
    .opcode   (opcode),
    .instr_a  (instr_a),
    .instr_b  (instr_b),
    .op       (op),
    .prog_len (prog_len),
    .running  (running),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic load_word(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o);
    send_byte(a);
    send_byte(b);
    send_byte(o);
  endtask

  // Pulse start, play the controller, and check every op against the
  // expected tables. First op at cycle 2 after start, then every 4 cycles;
  // done rises the cycle after the last op.
  task automatic run_prog(input int n, input string tag);
    int k;
    int done_cyc;
    k        = 0;
    done_cyc = -1;
    addr_in  = 4'd0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    for (int cyc = 1; cyc <= n * 4 + 8; cyc++) begin
      if (op) begin
        $display("%s op %0d: cycle=%0d opcode=0x%0h a=0x%0h b=0x%0h",
                 tag, k, cyc, opcode, instr_a, instr_b);
        if (k < 16) begin
          check({tag, "_opcode"}, 32'(opcode), 32'(exp_op[k]));
          check({tag, "_instr_a"}, 32'(instr_a), 32'(exp_a[k]));
          check({tag, "_instr_b"}, 32'(instr_b), 32'(exp_b[k]));
          check({tag, "_op_cycle"}, cyc, 2 + 4 * k);
        end
        k++;
        addr_in = addr_in + 4'd1;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      tick();
    end
    check({tag, "_op_count"}, k, n);
    check({tag, "_done_cycle"}, done_cyc, 4 * n - 1);
    check({tag, "_running_at_done"}, 32'(running), 0);
    check({tag, "_wr_ready_at_done"}, 32'(wr_ready), 0);
  endtask

  initial begin
    int k;
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    start    = 1'b0;
    addr_in  = 4'd0;
    tick();
    tick();
    reset = 1'b0;

    // ---- reset state ----
    check("rst_op", 32'(op), 0);
    check("rst_opcode", 32'(opcode), 0);
    check("rst_instr_a", 32'(instr_a), 0);
    check("rst_instr_b", 32'(instr_b), 0);
    check("rst_prog_len", 32'(prog_len), 0);
    check("rst_wr_ready", 32'(wr_ready), 1);
    check("rst_running", 32'(running), 0);
    check("rst_done", 32'(done), 0);
    $display("reset state sampled");

    // ---- start guards ----
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("guard_empty_running", 32'(running), 0);
    check("guard_empty_wr_ready", 32'(wr_ready), 1);
    $display("start with empty program");

    send_byte(8'h21);
    send_byte(8'h43);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("guard_partial_running", 32'(running), 0);
    check("guard_partial_prog_len", 32'(prog_len), 0);
    $display("start after two bytes");

    // Third byte and start in the same cycle: byte wins. 0xF8 -> opcode 8.
    wr_valid = 1'b1;
    wr_data  = 8'hF8;
    start    = 1'b1;
    tick();
    wr_valid = 1'b0;
    start    = 1'b0;
    check("guard_coincident_prog_len", 32'(prog_len), 1);
    tick();
    check("guard_coincident_running", 32'(running), 0);
    $display("start coincident with third byte");

    exp_a[0] = 8'h21; exp_b[0] = 8'h43; exp_op[0] = 4'h8;
    run_prog(1, "guard_run");

    // ---- single word ----
    do_reset();
    load_word(8'h05, 8'h03, 8'h00);
    check("one_prog_len", 32'(prog_len), 1);
    exp_a[0] = 8'h05; exp_b[0] = 8'h03; exp_op[0] = 4'h0;
    run_prog(1, "one");

    // ---- three words, preceded by a partial word discarded by reset ----
    do_reset();
    send_byte(8'hEE);
    do_reset();
    exp_a[0] = 8'h11; exp_b[0] = 8'h22; exp_op[0] = 4'h1;
    exp_a[1] = 8'h33; exp_b[1] = 8'h44; exp_op[1] = 4'h3;
    exp_a[2] = 8'h55; exp_b[2] = 8'h66; exp_op[2] = 4'h6;
    for (int i = 0; i < 3; i++) load_word(exp_a[i], exp_b[i], 8'(exp_op[i]));
    check("three_prog_len", 32'(prog_len), 3);
    run_prog(3, "three");

    // ---- reset mid-run after the second op ----
    do_reset();
    for (int i = 0; i < 3; i++) load_word(exp_a[i], exp_b[i], 8'(exp_op[i]));
    addr_in = 4'd0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      if (op) begin
        k++;
        addr_in = addr_in + 4'd1;
      end
      if (k == 2) break;
      tick();
    end
    check("midrst_ops_before", k, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_op", 32'(op), 0);
    check("midrst_prog_len", 32'(prog_len), 0);
    check("midrst_running", 32'(running), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_wr_ready", 32'(wr_ready), 1);
    check("midrst_opcode", 32'(opcode), 0);
    check("midrst_instr_a", 32'(instr_a), 0);
    check("midrst_instr_b", 32'(instr_b), 0);
    $display("reset after second op");

    // ---- full memory ----
    for (int i = 0; i < 16; i++) begin
      exp_a[i]  = 8'(8'h10 + i);
      exp_b[i]  = 8'(8'h80 + 3 * i);
      exp_op[i] = 4'(15 - i);
      load_word(exp_a[i], exp_b[i], {4'hA, exp_op[i]});
    end
    check("full_prog_len", 32'(prog_len), 16);
    check("full_wr_ready", 32'(wr_ready), 0);
    send_byte(8'h99);
    check("full_extra_byte_prog_len", 32'(prog_len), 16);
    $display("memory filled, extra byte offered");
    run_prog(16, "full");

    // DONE is terminal: no further op, start and bytes ignored.
    for (int c = 0; c < 6; c++) begin
      start    = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 8'h77;
      tick();
      check("post_done_op", 32'(op), 0);
      check("post_done_done", 32'(done), 1);
    end
    start    = 1'b0;
    wr_valid = 1'b0;
    check("post_done_prog_len", 32'(prog_len), 16);
    $display("terminal DONE held");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
